// File: rtl/tx_pkg.sv
// Shared types and constants for the parallel-to-serial lane transmitter.
package tx_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = $clog2(BYTE_W);

  // K28.5 COM payload used as lane filler.
  localparam logic [BYTE_W-1:0] IDLE_SYM_DFLT = 8'hBC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } tx_state_t;

  // Serial bit that leaves the shifter for a given register image.
  function automatic logic ser_bit(input logic [BYTE_W-1:0] v, input bit msb_first);
    return msb_first ? v[BYTE_W-1] : v[0];
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Byte shifter: parallel load on LOAD, otherwise one-bit shift toward the serial output.
module ser_shift_reg import tx_pkg::*; #(
  parameter logic [BYTE_W-1:0] RST_VAL   = IDLE_SYM_DFLT,
  parameter bit                MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOAD,
  input  logic [BYTE_W-1:0] LOAD_DATA,
  output logic              SER_OUT
);

  logic [BYTE_W-1:0] shift_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      shift_reg <= RST_VAL;
    else if (LOAD)
      shift_reg <= LOAD_DATA;
    else if (MSB_FIRST)
      shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
    else
      shift_reg <= {1'b0, shift_reg[BYTE_W-1:1]};
  end

  assign SER_OUT = ser_bit(shift_reg, MSB_FIRST);

endmodule

// File: rtl/par_to_ser_tx.sv
// Drains bytes from the upstream buffer through a one-byte holding register and
// serialises one byte per 8-cycle slot, filling empty slots with the idle symbol.
module par_to_ser_tx import tx_pkg::*; #(
  parameter logic [BYTE_W-1:0] IDLE_SYM  = IDLE_SYM_DFLT,
  parameter bit                MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [BYTE_W-1:0] DATA_IN,
  input  logic              VALID_IN,
  output logic              READ,
  output logic              DATA_OUT,
  output logic              BYTE_SYNC,
  output logic              IDLE_OUT,
  output logic              OVERFLOW
);

  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] hold_reg;
  logic              hold_valid;
  logic              ovf;
  tx_state_t         state, state_nxt;

  logic              load;
  logic              capture;
  logic [BYTE_W-1:0] load_data;

  // The edge that ends the last bit of a slot hands the next byte to the shifter.
  assign load      = (bit_cnt == CNT_W'(BYTE_W-1));
  assign capture   = VALID_IN && (!hold_valid || load);
  assign load_data = hold_valid ? hold_reg : IDLE_SYM;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      bit_cnt <= '0;
    else
      bit_cnt <= bit_cnt + CNT_W'(1);
  end

  // A capture on the load edge refills the slot that the shifter just emptied.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold_reg   <= '0;
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_reg   <= DATA_IN;
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      ovf <= 1'b0;
    else if (VALID_IN && hold_valid && !load)
      ovf <= 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = hold_valid ? ST_DATA : ST_IDLE;
  end

  ser_shift_reg #(
    .RST_VAL   (IDLE_SYM),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .CLK       (CLK),
    .RESET     (RESET),
    .LOAD      (load),
    .LOAD_DATA (load_data),
    .SER_OUT   (DATA_OUT)
  );

  assign BYTE_SYNC = (bit_cnt == '0);
  assign IDLE_OUT  = (state == ST_IDLE);
  assign READ      = (bit_cnt == '0) && !hold_valid;
  assign OVERFLOW  = ovf;

endmodule

// File: tb/tb_par_to_ser_tx.sv
// Directed bench for par_to_ser_tx: per-cycle expected serial stream built from hand-picked slot bytes.
module tb_par_to_ser_tx;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] DATA_IN = '0;
  logic       VALID_IN = 1'b0;
  logic       READ, DATA_OUT, BYTE_SYNC, IDLE_OUT, OVERFLOW;

  int n_chk = 0;
  int n_err = 0;

  logic       stim_v [0:63];
  logic [7:0] stim_d [0:63];

  par_to_ser_tx dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DATA_IN   (DATA_IN),
    .VALID_IN  (VALID_IN),
    .READ      (READ),
    .DATA_OUT  (DATA_OUT),
    .BYTE_SYNC (BYTE_SYNC),
    .IDLE_OUT  (IDLE_OUT),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_stim();
    for (int i = 0; i < 64; i++) begin
      stim_v[i] = 1'b0;
      stim_d[i] = 8'h00;
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, " DATA_OUT"},  {7'd0, DATA_OUT},  8'd1);
    chk({tag, " BYTE_SYNC"}, {7'd0, BYTE_SYNC}, 8'd1);
    chk({tag, " IDLE_OUT"},  {7'd0, IDLE_OUT},  8'd1);
    chk({tag, " READ"},      {7'd0, READ},      8'd1);
    chk({tag, " OVERFLOW"},  {7'd0, OVERFLOW},  8'd0);
  endtask

  // Leaves the bench just after a rising edge, at the start of slot 0 bit 0.
  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1;
    VALID_IN = 1'b0;
    @(negedge CLK);
    chk_rst_vals("rst");
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  // bytes[s]: byte in slot s; idl[s]: slot is filler; rd[s]: READ expected at slot s bit 0.
  task automatic run(input string name, input int ncyc, input logic [3:0][7:0] bytes,
                     input logic [3:0] idl, input logic [3:0] rd, input int ovf_from);
    int s, b;
    for (int c = 0; c < ncyc; c++) begin
      s = c / 8;
      b = c % 8;
      VALID_IN = stim_v[c];
      DATA_IN  = stim_d[c];
      @(negedge CLK);
      chk($sformatf("%s c%0d DATA_OUT", name, c),  {7'd0, DATA_OUT},  {7'd0, bytes[s][7-b]});
      chk($sformatf("%s c%0d BYTE_SYNC", name, c), {7'd0, BYTE_SYNC}, {7'd0, b == 0});
      chk($sformatf("%s c%0d IDLE_OUT", name, c),  {7'd0, IDLE_OUT},  {7'd0, idl[s]});
      chk($sformatf("%s c%0d READ", name, c),      {7'd0, READ},      {7'd0, (b == 0) && rd[s]});
      chk($sformatf("%s c%0d OVERFLOW", name, c),  {7'd0, OVERFLOW},  {7'd0, c >= ovf_from});
      @(posedge CLK); #1;
    end
    VALID_IN = 1'b0;
  endtask

  initial begin
    // idle stream after reset
    clr_stim();
    do_reset();
    run("idle", 24, {8'hBC, 8'hBC, 8'hBC, 8'hBC}, 4'b1111, 4'b1111, 1000);

    // single byte answered one cycle after the cycle-0 READ
    clr_stim();
    stim_v[1] = 1'b1; stim_d[1] = 8'hA5;
    do_reset();
    run("single", 24, {8'hBC, 8'hBC, 8'hA5, 8'hBC}, 4'b1101, 4'b1111, 1000);

    // back-to-back bytes, one per READ
    clr_stim();
    stim_v[1]  = 1'b1; stim_d[1]  = 8'h01;
    stim_v[9]  = 1'b1; stim_d[9]  = 8'h02;
    stim_v[17] = 1'b1; stim_d[17] = 8'h03;
    do_reset();
    run("b2b", 32, {8'h03, 8'h02, 8'h01, 8'hBC}, 4'b0001, 4'b1111, 1000);

    // overflow: 8'h22 arrives at bit 3 while 8'h11 is held
    clr_stim();
    stim_v[1] = 1'b1; stim_d[1] = 8'h11;
    stim_v[3] = 1'b1; stim_d[3] = 8'h22;
    do_reset();
    run("ovf", 24, {8'hBC, 8'hBC, 8'h11, 8'hBC}, 4'b1101, 4'b1111, 4);

    // capture on the load edge while 8'h44 is held; READ stays low at slot 1
    clr_stim();
    stim_v[3] = 1'b1; stim_d[3] = 8'h44;
    stim_v[7] = 1'b1; stim_d[7] = 8'h33;
    do_reset();
    run("ldcap", 32, {8'hBC, 8'h33, 8'h44, 8'hBC}, 4'b1001, 4'b1101, 1000);

    // reset at bit 4 of a data byte, with overflow set and a byte held
    clr_stim();
    stim_v[1] = 1'b1; stim_d[1] = 8'hA5;
    stim_v[3] = 1'b1; stim_d[3] = 8'h22;
    stim_v[9] = 1'b1; stim_d[9] = 8'h5A;
    do_reset();
    run("pre_abort", 12, {8'hBC, 8'hBC, 8'hA5, 8'hBC}, 4'b1101, 4'b1111, 4);
    #2 RESET = 1'b1;
    #1 chk_rst_vals("abort");
    clr_stim();
    @(posedge CLK); #1;
    RESET = 1'b0;
    run("post_abort", 16, {8'hBC, 8'hBC, 8'hBC, 8'hBC}, 4'b1111, 4'b1111, 1000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/par_to_ser_tx.md
Name: par_to_ser_tx

Overview:
- Downstream neighbour of the 8-byte buffer: drains bytes from it via a READ strobe and serialises them 1 bit/clock onto the lane.
- Keeps the lane alive with an idle symbol whenever no byte is waiting.
- Uses a one-byte holding register so that the buffer's one-cycle read latency never starves the shifter.
- Sits between the buffer's DATA_OUT/Valid and the lane driver.

Parameters:
- IDLE_SYM, 8'hBC: byte transmitted when no data is available (K28.5 COM payload).
- MSB_FIRST, 1: 1 = bit 7 is transmitted first; 0 = bit 0 is transmitted first.

Ports:
- CLK  input  1  single clock; bit rate = CLK rate.
- RESET  input  1  asynchronous, active-high reset.
- DATA_IN  input  8  byte from the upstream buffer.
- VALID_IN  input  1  DATA_IN is valid this cycle; sampled only at rising CLK edges.
- READ  output  1  one-cycle request to the upstream buffer for the next byte.
- DATA_OUT  output  1  serial bit.
- BYTE_SYNC  output  1  high during the first bit of every transmitted byte.
- IDLE_OUT  output  1  high for all 8 bits of a byte that is IDLE_SYM filler.
- OVERFLOW  output  1  sticky: a byte arrived while the holding register was full.

Behaviour:
- Clock and reset: one clock (CLK). RESET is asynchronous and active-high; every register clears immediately on assertion.
- Registers:
  - shift_reg[7:0], reset value IDLE_SYM.
  - bit_cnt[2:0], reset value 0.
  - hold_reg[7:0], reset value 0.
  - hold_valid, reset value 0.
  - state, reset value ST_IDLE.
  - ovf, reset value 0.
- Outputs are combinational from registers only:
  - DATA_OUT = shift_reg[7] if MSB_FIRST, else shift_reg[0].
  - BYTE_SYNC = (bit_cnt==0).
  - IDLE_OUT = (state==ST_IDLE).
  - READ = (bit_cnt==0) && !hold_valid.
  - OVERFLOW = ovf.
- Output values while RESET is high: DATA_OUT = IDLE_SYM first bit, BYTE_SYNC = 1, IDLE_OUT = 1, READ = 1, OVERFLOW = 0.
- bit_cnt increments every cycle and wraps 7 -> 0. Each 8-cycle slot carries exactly one byte. shift_reg shifts by one toward the output end each cycle for bit_cnt 0..6.
- Load edge (edge that ends bit_cnt==7):
  - If hold_valid: shift_reg <= hold_reg, hold_valid <= 0, state <= ST_DATA.
  - Otherwise: shift_reg <= IDLE_SYM, state <= ST_IDLE.
- FSM summary: ST_IDLE and ST_DATA change only at load edges.
  - ST_IDLE -> ST_DATA when hold_valid is set at the load edge.
  - ST_DATA -> ST_IDLE when hold_valid is clear at the load edge.
  - ST_DATA -> ST_DATA (back-to-back bytes, no idle gap) when hold_valid is set at the load edge.
- Capture:
  - On any edge with VALID_IN high, hold_reg <= DATA_IN and hold_valid <= 1, provided hold_valid is 0 or this edge is a load edge.
  - Capture on a load edge overrides the consumption clear, so hold_valid stays 1.
- Overflow: VALID_IN high while hold_valid==1 on a non-load edge -> byte dropped, hold_reg unchanged, ovf <= 1. ovf clears only on RESET.
- Latency: the upstream buffer returns VALID_IN one cycle after READ. A byte requested at slot k bit 0 is transmitted in slot k+1, so DATA_IN to first serial bit is at most 15 cycles.
- READ in the first slot after reset is high (hold empty). After reset deasserts, the first slot is IDLE_SYM.
- Reset mid-byte: transmission aborts. The line restarts with a full IDLE_SYM byte with BYTE_SYNC high, and any held byte is discarded.
- VALID_IN without a preceding READ is legal and captured under the same rules.

Decomposition:
- Shared package (tx_pkg):
  - IDLE_SYM default constant 8'hBC.
  - tx_state_t enum {ST_IDLE, ST_DATA}.
  - BYTE_W = 8.
- Sub-module ser_shift_reg: parallel load, shift by one per cycle, MSB_FIRST parameter, serial output.
- Control logic (bit_cnt, hold register, FSM, READ, overflow) stays in par_to_ser_tx.

Test Plan:
- Reset then no VALID_IN for 24 cycles:
  - DATA_OUT repeats 1,0,1,1,1,1,0,0 three times.
  - IDLE_OUT = 1 throughout; BYTE_SYNC high at cycles 0, 8, 16.
  - READ high at cycles 0, 8, 16.
- Single byte: VALID_IN=1 with DATA_IN=8'hA5 one cycle after the cycle-0 READ:
  - slot 1 (cycles 8-15) carries 1,0,1,0,0,1,0,1 with IDLE_OUT=0.
  - slot 2 returns to IDLE_SYM.
  - READ is low in slot 1 bit 0 only if a new byte is already held.
- Back-to-back: answer every READ with 8'h01, 8'h02, 8'h03:
  - three consecutive data slots, no idle gap, IDLE_OUT=0 for 24 cycles.
- Overflow: hold filled with 8'h11, then VALID_IN with 8'h22 at bit_cnt=3:
  - OVERFLOW rises and stays high.
  - 8'h11 is transmitted; 8'h22 never appears.
- Simultaneous load and capture: VALID_IN with 8'h33 on the load edge while 8'h44 is held:
  - 8'h44 is transmitted, then 8'h33 in the next slot; no overflow.
- RESET asserted at bit_cnt=4 of a data byte:
  - all outputs take reset values immediately.
  - after release, a full IDLE_SYM byte with BYTE_SYNC at the first cycle; OVERFLOW=0.
